// File: rtl/entropy_pkg.sv
// entropy_pkg: shared FSM encoding, gap width and source-count limits for entropy_scheduler
`ifndef WB_WIDTH
`define WB_WIDTH 32
`endif
package entropy_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, INJECT = 2'd1, COOL = 2'd2} state_t;
  localparam int GAP_W = 8;
  localparam int NUM_SRC_MIN = 2;
  localparam int NUM_SRC_MAX = 8;
endpackage

// File: rtl/entropy_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after last
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  localparam int IW = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IW-1:0]      idx
);
  logic [IW-1:0] c;
  always_comb begin
    gnt = '0;
    idx = '0;
    c = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      c = IW'((int'(last) + k) % NUM_SRC);
      if (req[c]) begin
        gnt = NUM_SRC'(1) << c;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/entropy_scheduler.sv
// entropy_scheduler: round-robin feed of source words into the pool with cool-down (ENTROPY_SCHED_STATS_EN adds inj_count)
module entropy_scheduler
  import entropy_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int WIDTH = `WB_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [7:0]               cfg_gap,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*WIDTH-1:0] src_word,
  output logic [NUM_SRC-1:0]       src_ready,
  output logic [WIDTH-1:0]         e_word,
  output logic                     busy
`ifdef ENTROPY_SCHED_STATS_EN
  ,
  output logic [31:0]              inj_count
`endif
);
  localparam int IW = $clog2(NUM_SRC);
  state_t state;
  logic [IW-1:0] last, win_idx;
  logic [NUM_SRC-1:0] win_gnt;
  logic [WIDTH-1:0] word_q;
  logic [GAP_W-1:0] gap_cnt;
  logic xfer;
  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .req(src_valid),
    .last(last),
    .gnt(win_gnt),
    .idx(win_idx)
  );
  assign src_ready = (state == IDLE && en) ? win_gnt : '0;
  assign xfer = |src_ready;
  assign e_word = word_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= IW'(NUM_SRC - 1);
      word_q <= '0;
      gap_cnt <= '0;
      busy <= 1'b0;
    end else begin
      word_q <= xfer ? src_word[win_idx*WIDTH +: WIDTH] : '0;
      if (xfer) begin
        last <= win_idx;
        gap_cnt <= cfg_gap;
      end else if (state == COOL)
        gap_cnt <= gap_cnt - 1'b1;
      state <= xfer ? INJECT :
               state == INJECT ? (gap_cnt == '0 ? IDLE : COOL) :
               state == COOL ? (gap_cnt == GAP_W'(1) ? IDLE : COOL) : IDLE;
      busy <= xfer | (state == INJECT && gap_cnt != '0) | (state == COOL && gap_cnt != GAP_W'(1));
    end
  end
`ifdef ENTROPY_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) inj_count <= '0;
    else if (xfer) inj_count <= inj_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_entropy_scheduler.sv
// tb_entropy_scheduler: randomized scoreboard bench for entropy_scheduler against a transaction-level model
module tb_entropy_scheduler;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [7:0] cfg_gap = '0;
  logic [N-1:0] src_valid = '0;
  logic [N-1:0] src_ready;
  logic [N*W-1:0] src_word = '0;
  logic [W-1:0] e_word;
  logic busy;
`ifdef ENTROPY_SCHED_STATS_EN
  logic [31:0] inj_count;
`endif
  typedef struct {logic [W-1:0] w; int due;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  bit run = 1'b0;
  always #5 clk = ~clk;
  entropy_scheduler #(.NUM_SRC(N), .WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .cfg_gap(cfg_gap),
    .src_valid(src_valid),
    .src_word(src_word),
    .src_ready(src_ready),
    .e_word(e_word),
    .busy(busy)
`ifdef ENTROPY_SCHED_STATS_EN
    ,
    .inj_count(inj_count)
`endif
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (run) begin
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check("e_word", e_word, e.w);
      end else
        check("e_word_idle", e_word, 32'd0);
    end
  end
  initial begin
    logic [W-1:0] wd [N];
    bit pend [N];
    logic [N-1:0] acc, exp_rdy;
    int last, next_ok, busy_from, busy_to, gapv, cnt;
    for (int i = 0; i < N; i++) begin
      wd[i] = '0;
      pend[i] = 1'b0;
    end
    acc = '0;
    last = N - 1;
    next_ok = 0;
    busy_from = 0;
    busy_to = -1;
    cnt = 0;
    repeat (2) @(posedge clk);
    run = 1'b1;
    for (int k = 0; k < 2040; k++) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) if (acc[i]) pend[i] = 1'b0;
      rst = (cyc == 1) || (cyc > 100 && cyc < 2000 && cyc == busy_from && $urandom_range(0, 7) == 0);
      en = (cyc < 100 || cyc >= 2000) ? 1'b1 : ($urandom_range(0, 4) != 0);
      cfg_gap = cyc < 60 ? 8'd0 : cyc < 100 ? ($urandom_range(0, 1) == 1 ? 8'd3 : 8'd10) : 8'($urandom_range(0, 4));
      for (int i = 0; i < N; i++)
        if (!pend[i] && (cyc < 20 ? i == 0 : cyc < 100 ? 1'b1 : cyc < 2000 ? $urandom_range(0, 1) == 1 : 1'b0)) begin
          pend[i] = 1'b1;
          wd[i] = cyc < 20 ? 32'hA5A5A5A5 : ($urandom | 32'd1);
        end
      for (int i = 0; i < N; i++) begin
        src_valid[i] = pend[i];
        src_word[i*W +: W] = wd[i];
      end
      #1;
      exp_rdy = '0;
      if (en && cyc >= next_ok)
        for (int j = 1; j <= N; j++)
          if (pend[(last + j) % N]) begin
            exp_rdy[(last + j) % N] = 1'b1;
            break;
          end
      check("busy", busy, cyc >= busy_from && cyc <= busy_to);
`ifdef ENTROPY_SCHED_STATS_EN
      check("inj_count", inj_count, cnt);
`endif
      acc = '0;
      gapv = int'(cfg_gap);
      if (rst) begin
        last = N - 1;
        next_ok = cyc + 1;
        busy_from = 0;
        busy_to = -1;
        cnt = 0;
        if (q.size() != 0 && q[$].due > cyc) void'(q.pop_back());
      end else begin
        check("src_ready", src_ready, exp_rdy);
        acc = src_valid & src_ready;
        for (int j = 0; j < N; j++)
          if (exp_rdy[j]) begin
            q.push_back('{wd[j], cyc + 1});
            busy_from = cyc + 1;
            busy_to = cyc + 1 + gapv;
            next_ok = cyc + 2 + gapv;
            last = j;
            cnt++;
          end
      end
    end
    @(negedge clk);
    #3;
    check("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/entropy_scheduler.md
# entropy_scheduler

- Round-robin scheduler that shares the entropy pool's single `e_word` input between `NUM_SRC` entropy sources.
- Accepts at most one word per grant over a valid/ready handshake.
- Presents the granted word to the pool for exactly one cycle, then enforces a programmable cool-down so consecutive words do not XOR over each other in the pool's shift window.
- Sits between the entropy sources (ring oscillators, Wishbone host writes, timing jitter taps) and the pool; its `e_word` output drives the pool's `e_word` input directly.

## Interface

Parameters:
- `NUM_SRC`, default 4: number of requesting sources, 2..8.
- `WIDTH`, default `` `WB_WIDTH``: entropy word width.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset; one clock, synchronous, active-high.
- `en`, in, 1: scheduler enable; gates new grants only.
- `cfg_gap`, in, 8: cool-down length in cycles after each injection.
- `src_valid`, in, `NUM_SRC`: per-source word offered.
- `src_word`, in, `NUM_SRC*WIDTH`: packed words; source i occupies bits `[i*WIDTH +: WIDTH]`.
- `src_ready`, out, `NUM_SRC`: one-hot grant; a transfer occurs on `src_valid[i] & src_ready[i]`.
- `e_word`, out, `WIDTH`: word to the pool; zero except during INJECT.
- `busy`, out, 1: high in INJECT or COOL.

## Operation

- States: IDLE, INJECT, COOL.
- IDLE:
  - With `en`=1 and any `src_valid` high, `src_ready` is asserted combinationally for exactly one source, the winner.
  - Winner: first valid source scanning upward from `last+1` mod `NUM_SRC`.
  - The transfer latches the winner's word into `word_q` and sets `last` to the winner. Next state is INJECT.
  - `src_ready` is all-zero when `en`=0 or no source is valid.
- INJECT, one cycle:
  - `e_word` = `word_q`.
  - Next state is IDLE if the latched gap is 0, otherwise COOL with `gap_cnt` = latched gap.
- COOL:
  - `gap_cnt` decrements each cycle; the state exits to IDLE after `gap_cnt` reaches 1.
  - `cfg_gap` is sampled at the IDLE transfer. Changes during INJECT or COOL do not affect the current cool-down.
- `src_ready` is zero in INJECT and COOL.
- Sources hold `src_valid` and `src_word` stable until accepted. The scheduler never drops an offered word.
- Deasserting `en` does not abort INJECT or COOL; only the next grant is held off.
- Reset values:
  - State is IDLE.
  - `last` = `NUM_SRC-1`, so source 0 has first priority.
  - `word_q` = 0, `gap_cnt` = 0.
  - `e_word` = 0, `src_ready` = 0, `busy` = 0.
- Reset asserted in INJECT or COOL: the in-flight word is discarded, state goes to IDLE, and outputs are zero on the next cycle.

## Timing

- Transfer at cycle T (IDLE) → `e_word` valid at T+1 only → earliest next grant at T+2+gap.
- Throughput is one word per 2+`cfg_gap` cycles.
- `src_ready` is combinational from `src_valid`, `en` and state.
- `e_word` and `busy` are registered.

## Configuration

- `ENTROPY_SCHED_STATS_EN`, defined:
  - Adds output port `inj_count` [31:0], reset 0.
  - Increments by 1 on every transfer and wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure

- `entropy_pkg`: state encoding (IDLE=0, INJECT=1, COOL=2), gap width constant (8), and `NUM_SRC` limits.
- Sub-module `rr_arbiter`: parameterised `NUM_SRC`.
  - Inputs: request vector, `last` pointer.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
- The FSM, `word_q`, `gap_cnt`, `last` and the optional stats counter live in `entropy_scheduler`.

## Test plan

- Reset, then idle:
  - `e_word`, `src_ready` and `busy` are 0.
  - With `src_valid[0]`=1, `src_ready`=0001 on the first post-reset cycle.
- Single source, `cfg_gap`=0, word 0xA5A5A5A5:
  - `e_word`=0xA5A5A5A5 for exactly one cycle.
  - The next grant to the same source occurs 2 cycles after the previous transfer.
- All four sources valid continuously, `cfg_gap`=0:
  - Grant order 0,1,2,3,0.
  - Each source's word appears on `e_word` once per cycle of the order, never duplicated.
- `cfg_gap`=3:
  - Transfer at T, `e_word` at T+1, `busy` high T+1..T+4, next `src_ready` at T+5.
  - `cfg_gap` changed to 10 at T+2 does not alter this timing.
- `en` dropped during COOL:
  - COOL completes and no grant is given.
  - `en` reasserted → grant goes to the source after `last`.
- `rst` pulsed during INJECT:
  - `e_word`=0 the next cycle and state is IDLE.
  - First grant goes to source 0.
  - With `ENTROPY_SCHED_STATS_EN`, `inj_count` is 0 after reset and increments once per transfer.
